fpdiv: RTL and testbench

- Sequential IEEE-754-style floating-point divider: out = a / b.
- Companion to the team's fpmul; same operand format and the same start/ready handshake style.
- Mantissa quotient is produced by a radix-2 restoring divider, one bit per clock.
- Fixed latency regardless of operand class, so the pipeline scheduler can treat it like the multiplier.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fpseperator.sv | 36 +++
 rtl/unsigned_divider.sv | 55 +++++
 rtl/fpdiv.sv | 169 ++++++++++++++++
 tb/tb_fpdiv.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point types and format constants for the fp arithmetic units.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} fpdiv_state_e;

  function automatic int fp_bias(input int exp_bit);
    return (1 << (exp_bit - 1)) - 1;
  endfunction

  // Magnitude bit patterns (sign excluded); callers truncate to N_BIT-1.
  function automatic logic [63:0] fp_inf(input int exp_bit, input int man_bit);
    return ((64'd1 << exp_bit) - 64'd1) << man_bit;
  endfunction

  function automatic logic [63:0] fp_nan(input int exp_bit, input int man_bit);
    return fp_inf(exp_bit, man_bit) | (64'd1 << (man_bit - 1));
  endfunction

endpackage

// File: rtl/fpseperator.sv
// Splits a packed float into sign, exponent, mantissa with hidden bit, and class.
// Denormals are reported as ZERO with a cleared mantissa.
module fpseperator
  import fp_pkg::*;
#(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  localparam int N_BIT = 1 << LOG_BIT,
  localparam int MAN_BIT = N_BIT - EXP_BIT - 1
) (
  input  logic [N_BIT-1:0]   value,
  output logic               sign,
  output logic [EXP_BIT-1:0] exp,
  output logic [MAN_BIT:0]   man,
  output fp_class_e          cls
);

  logic [MAN_BIT-1:0] frac;

  assign sign = value[N_BIT-1];
  assign exp  = value[N_BIT-2 -: EXP_BIT];
  assign frac = value[MAN_BIT-1:0];

  always_comb begin
    cls = NORMAL;
    man = {1'b1, frac};
    if (exp == '0) begin
      cls = ZERO;
      man = '0;
    end else if (&exp) begin
      cls = (frac == '0) ? INF : NAN;
      man = {1'b0, frac};
    end
  end

endmodule

// File: rtl/unsigned_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, MSB first.
// rem_nz reports a nonzero final remainder for sticky rounding.
module unsigned_divider #(
  parameter int N_BIT   = 24,
  parameter int QUO_BIT = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_BIT-1:0]   dividend,
  input  logic [N_BIT-1:0]   divisor,
  output logic [QUO_BIT-1:0] quotient,
  output logic               rem_nz,
  output logic               ready
);

  localparam int CW = $clog2(QUO_BIT);

  logic [N_BIT:0]   rem;
  logic [N_BIT-1:0] div;
  logic [N_BIT-1:0] diff;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             take;

  // rem < 2*div always holds, so the difference fits in N_BIT bits.
  assign take   = rem >= {1'b0, div};
  assign diff   = rem[N_BIT-1:0] - div;
  assign ready  = !busy;
  assign rem_nz = |rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      div      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (!busy) begin
      if (start) begin
        rem      <= {1'b0, dividend};
        div      <= divisor;
        quotient <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
      end
    end else begin
      rem      <= take ? {diff, 1'b0} : {rem[N_BIT-1:0], 1'b0};
      quotient <= {quotient[QUO_BIT-2:0], take};
      cnt      <= cnt + CW'(1);
      if (cnt == CW'(QUO_BIT - 1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fpdiv.sv
// Sequential floating-point divider out = a / b with fixed MAN_BIT+4 cycle latency.
// Define FPDIV_STATUS_FLAGS_EN to add flags = {invalid, div_by_zero, overflow, underflow}.
module fpdiv
  import fp_pkg::*;
#(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  localparam int N_BIT = 1 << LOG_BIT,
  localparam int MAN_BIT = N_BIT - EXP_BIT - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             start,
  output logic [N_BIT-1:0] out,
  output logic             ready,
  output logic             done
`ifdef FPDIV_STATUS_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int EW      = EXP_BIT + 2;
  localparam int QUO_BIT = MAN_BIT + 3;
  localparam int CW      = $clog2(QUO_BIT);
  localparam logic [EW-1:0] BIAS    = EW'(fp_bias(EXP_BIT));
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_BIT) - 1);
  localparam logic [N_BIT-2:0] INF_MAG = (N_BIT-1)'(fp_inf(EXP_BIT, MAN_BIT));
  localparam logic [N_BIT-2:0] NAN_MAG = (N_BIT-1)'(fp_nan(EXP_BIT, MAN_BIT));

  logic               sa, sb;
  logic [EXP_BIT-1:0] ea, eb;
  logic [MAN_BIT:0]   ma, mb;
  fp_class_e          ca, cb;

  fpseperator #(.LOG_BIT(LOG_BIT), .EXP_BIT(EXP_BIT)) u_sep_a (
    .value(a), .sign(sa), .exp(ea), .man(ma), .cls(ca)
  );
  fpseperator #(.LOG_BIT(LOG_BIT), .EXP_BIT(EXP_BIT)) u_sep_b (
    .value(b), .sign(sb), .exp(eb), .man(mb), .cls(cb)
  );

  logic [QUO_BIT-1:0] quo;
  logic               rem_nz;
  logic               div_ready;
  logic               accept;
  fpdiv_state_e       state, state_n;
  logic [CW-1:0]      counter;
  logic               sign_r;
  fp_class_e          ca_r, cb_r;
  logic [EW-1:0]      exp_r;

  assign ready  = (state == IDLE);
  assign accept = start && ready && div_ready;

  unsigned_divider #(.N_BIT(MAN_BIT + 1), .QUO_BIT(QUO_BIT)) u_div (
    .clk(clk), .rst(rst), .start(accept), .dividend(ma), .divisor(mb),
    .quotient(quo), .rem_nz(rem_nz), .ready(div_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = DIVIDE;
      DIVIDE:  if (counter == CW'(QUO_BIT - 1)) state_n = ROUND;
      ROUND:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic [MAN_BIT:0]   mant;
  logic [MAN_BIT+1:0] mant_r;
  logic [MAN_BIT-1:0] frac;
  logic [EW-1:0]      exp_n, exp_f;
  logic               guard_b, round_b, round_up, carry;
  logic               is_nan, is_inf, is_zero, overflow, underflow;
  logic [N_BIT-1:0]   result;

  // A quotient below 1.0 is normalized by one left shift; the bit shifted in
  // is covered by the sticky remainder, so round-to-nearest-even stays exact.
  always_comb begin
    if (quo[QUO_BIT-1]) begin
      mant    = quo[QUO_BIT-1:2];
      guard_b = quo[1];
      round_b = quo[0];
      exp_n   = exp_r;
    end else begin
      mant    = quo[QUO_BIT-2:1];
      guard_b = quo[0];
      round_b = 1'b0;
      exp_n   = exp_r - EW'(1);
    end
    round_up = guard_b & (round_b | rem_nz | mant[0]);
    mant_r   = {1'b0, mant} + (MAN_BIT+2)'(round_up);
    carry    = mant_r[MAN_BIT+1];
    frac     = carry ? mant_r[MAN_BIT:1] : mant_r[MAN_BIT-1:0];
    exp_f    = exp_n + EW'(carry);

    is_nan    = (ca_r == NAN) || (cb_r == NAN) || (ca_r == ZERO && cb_r == ZERO) ||
                (ca_r == INF && cb_r == INF);
    is_inf    = (ca_r == INF) || (cb_r == ZERO);
    is_zero   = (cb_r == INF) || (ca_r == ZERO);
    overflow  = !exp_f[EW-1] && (exp_f >= EXP_MAX);
    underflow = exp_f[EW-1] || (exp_f == '0);

    result = {sign_r, exp_f[EXP_BIT-1:0], frac};
    if (is_nan)         result = {sign_r, NAN_MAG};
    else if (is_inf)    result = {sign_r, INF_MAG};
    else if (is_zero)   result = {sign_r, {(N_BIT-1){1'b0}}};
    else if (overflow)  result = {sign_r, INF_MAG};
    else if (underflow) result = {sign_r, {(N_BIT-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      out     <= '0;
      done    <= 1'b0;
      sign_r  <= 1'b0;
      ca_r    <= ZERO;
      cb_r    <= ZERO;
      exp_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          counter <= '0;
          sign_r  <= sa ^ sb;
          ca_r    <= ca;
          cb_r    <= cb;
          exp_r   <= {2'b00, ea} - {2'b00, eb} + BIAS;
        end
        DIVIDE: counter <= counter + CW'(1);
        ROUND: begin
          out     <= result;
          done    <= 1'b1;
          counter <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef FPDIV_STATUS_FLAGS_EN
  logic [3:0] flags_n;

  always_comb begin
    flags_n = '0;
    if (is_nan)         flags_n[3] = 1'b1;
    else if (is_inf)    flags_n[2] = (ca_r == NORMAL) && (cb_r == ZERO);
    else if (is_zero)   flags_n    = '0;
    else if (overflow)  flags_n[1] = 1'b1;
    else if (underflow) flags_n[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                flags <= '0;
    else if (state == ROUND) flags <= flags_n;
  end
`endif

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed cases, handshake/reset, random and back-to-back runs
// against a real-arithmetic reference model.
module tb_fpdiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] out;
  logic        ready;
  logic        done;
`ifdef FPDIV_STATUS_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  fpdiv dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start),
    .out(out), .ready(ready), .done(done)
`ifdef FPDIV_STATUS_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  // 0 zero/denormal, 1 normal, 2 inf, 3 NaN
  function automatic int cls_of(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 2 : 3;
    return 1;
  endfunction

  function automatic real mag_to_real(input logic [31:0] x);
    logic [10:0] e11;
    e11 = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({1'b0, e11, x[22:0], 29'd0});
  endfunction

  // Double precision holds the float quotient well enough that a second
  // nearest-even rounding to single gives the correctly rounded result.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] fl);
    int          cx, cy, e;
    logic        s, rb;
    logic [63:0] d;
    logic [24:0] m;
    cx = cls_of(x);
    cy = cls_of(y);
    s  = x[31] ^ y[31];
    fl = 4'b0000;
    if (cx == 3 || cy == 3 || (cx == 0 && cy == 0) || (cx == 2 && cy == 2)) begin
      r = {s, 8'hFF, 1'b1, 22'd0};
      fl = 4'b1000;
    end else if (cx == 2 || cy == 0) begin
      r = {s, 8'hFF, 23'd0};
      if (cy == 0 && cx == 1) fl = 4'b0100;
    end else if (cy == 2 || cx == 0) begin
      r = {s, 31'd0};
    end else begin
      d  = $realtobits(mag_to_real(x) / mag_to_real(y));
      e  = int'(d[62:52]) - 1023 + 127;
      rb = d[28] & ((|d[27:0]) | d[29]);
      m  = 25'({1'b1, d[51:29]}) + 25'(rb);
      if (m[24]) e = e + 1;
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        fl = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        fl = 4'b0001;
      end else begin
        r = {s, 8'(e), m[24] ? 23'd0 : m[22:0]};
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b);
    int guard_cnt = 0;
    while (!ready && guard_cnt < 100) begin
      @(negedge clk);
      guard_cnt++;
    end
    checkOutput("accept_ready", 32'(ready), 32'd1);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic doDivide(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_out, input logic [3:0] exp_flags,
                          input int p1, input int p2);
    int n = 0;
    int pulses = 0;
    applyStimulus(op_a, op_b);
    checkOutput({tag, "_busy"}, 32'(ready), 32'd0);
    while (!ready && n < 60) begin
      start = (n == p1) || (n == p2);
      if (start) begin
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
      n++;
      if (done && !ready) pulses++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 32'(n), 32'd27);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_early_done"}, 32'(pulses), 32'd0);
    checkOutput({tag, "_out"}, out, exp_out);
`ifdef FPDIV_STATUS_FLAGS_EN
    checkOutput({tag, "_flags"}, 32'(flags), 32'(exp_flags));
`else
    if (exp_flags == 4'hF) $display("[TB] note: unused flag pattern");
`endif
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  task automatic doModel(input string tag, input logic [31:0] op_a, input logic [31:0] op_b);
    logic [31:0] r;
    logic [3:0]  fl;
    ref_div(op_a, op_b, r, fl);
    doDivide(tag, op_a, op_b, r, fl, -1, -1);
  endtask

  function automatic logic [31:0] rand_normal();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] bb_a [4];
    logic [31:0] bb_b [4];
    logic [31:0] bb_r [4];
    logic [3:0]  bb_f [4];
    int n;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out", out, 32'h0);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
`ifdef FPDIV_STATUS_FLAGS_EN
    checkOutput("reset_flags", 32'(flags), 32'd0);
`endif

    doDivide("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, -1, -1);
    doDivide("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, -1, -1);
    doDivide("neg_third", 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000, -1, -1);
    doDivide("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, -1, -1);
    doDivide("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, -1, -1);
    doDivide("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, -1, -1);
    doDivide("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, -1, -1);
    doDivide("two_by_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, -1, -1);
    doDivide("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, -1, -1);
    doDivide("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, -1, -1);
    doDivide("denormal", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, -1, -1);
    doDivide("busy_start", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 5, 12);

    // Abort mid-operation; a fresh start must still give a normal result.
    applyStimulus(32'h40C00000, 32'h40000000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_out", out, 32'h0);
    checkOutput("abort_done", 32'(done), 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    checkOutput("abort_no_done", 32'(n), 32'd0);
    doDivide("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, -1, -1);

    for (int i = 0; i < 4; i++) doModel("rand_norm", rand_normal(), rand_normal());
    for (int i = 0; i < 6; i++) doModel("rand_any", $urandom, $urandom);

    for (int k = 0; k < 4; k++) begin
      bb_a[k] = rand_normal();
      bb_b[k] = rand_normal();
      ref_div(bb_a[k], bb_b[k], bb_r[k], bb_f[k]);
    end
    checkOutput("b2b_idle", 32'(ready), 32'd1);
    a = bb_a[0];
    b = bb_b[0];
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("b2b_busy", 32'(ready), 32'd0);
      n = 0;
      while (!ready && n < 60) begin
        @(negedge clk);
        n++;
      end
      checkOutput("b2b_latency", 32'(n), 32'd27);
      checkOutput("b2b_done", 32'(done), 32'd1);
      checkOutput("b2b_out", out, bb_r[k]);
`ifdef FPDIV_STATUS_FLAGS_EN
      checkOutput("b2b_flags", 32'(flags), 32'(bb_f[k]));
`endif
      if (k < 3) begin
        a = bb_a[k+1];
        b = bb_b[k+1];
      end else begin
        start = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
